// File: rtl/am_lock_rx.sv
// Per-lane alignment-marker lock for the 40G PCS receive path: hunts for AMs, identifies
// each physical lane's virtual lane and flags AMs in the registered block stream.
module am_lock_rx #(
    parameter int LANE_N     = 4,
    parameter int BLOCK_W    = 66,
    parameter int AM_PERIOD  = 16384,
    parameter int AM_INV_MAX = 4
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic                      valid_i,
    input  logic [LANE_N-1:0]         block_lock_i,
    input  logic [LANE_N*BLOCK_W-1:0] block_i,
    output logic                      valid_o,
    output logic [LANE_N*BLOCK_W-1:0] block_o,
    output logic [LANE_N-1:0]         am_o,
    output logic [LANE_N-1:0]         am_lock_o,
    output logic [LANE_N*LANE_N-1:0]  lane_o,
    output logic                      lane_aligned_o
);

    localparam int CNT_W = $clog2(AM_PERIOD + 1);
    localparam int INV_W = $clog2(AM_INV_MAX + 1);
    localparam int ID_W  = 2;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(AM_PERIOD);
    localparam logic [INV_W-1:0] INV_ONE = INV_W'(1);
    localparam logic [INV_W-1:0] INV_END = INV_W'(AM_INV_MAX);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Marker bytes packed as {M2, M1, M0}; M0 sits in the lowest payload byte.
    function automatic logic [23:0] am_pattern(input logic [ID_W-1:0] id);
        case (id)
            2'd0:    return 24'h477690;
            2'd1:    return 24'hE6C4F0;
            2'd2:    return 24'h9B65C5;
            default: return 24'h3D79A2;
        endcase
    endfunction

    function automatic logic am_hit(input logic [1:0] hdr, input logic [23:0] m,
                                    input logic [23:0] m_inv, input logic [ID_W-1:0] id);
        logic [23:0] pat;
        pat = am_pattern(id);
        return (hdr == 2'b10) && (m == pat) && (m_inv == ~pat);
    endfunction

    state_t                 state_q [LANE_N];
    state_t                 state_d [LANE_N];
    logic [CNT_W-1:0]       cnt_q   [LANE_N];
    logic [CNT_W-1:0]       cnt_d   [LANE_N];
    logic [INV_W-1:0]       inv_q   [LANE_N];
    logic [INV_W-1:0]       inv_d   [LANE_N];
    logic [ID_W-1:0]        id_q    [LANE_N];
    logic [ID_W-1:0]        id_d    [LANE_N];
    logic [ID_W-1:0]        hit_id  [LANE_N];
    logic [LANE_N-1:0]      hit_any, hit_cap, exp_pos;

    logic                      valid_q, valid_d;
    logic [LANE_N*BLOCK_W-1:0] block_q, block_d;
    logic [LANE_N-1:0]         am_q, am_d;
    logic [LANE_N-1:0]         lock_q, lock_d;
    logic [LANE_N*LANE_N-1:0]  lane_q, lane_d;
    logic [LANE_N-1:0]         col_or;
    logic                      aligned_q, aligned_d;

    always_comb begin
        for (int x = 0; x < LANE_N; x++) begin
            hit_any[x] = 1'b0;
            hit_id[x]  = '0;
            hit_cap[x] = am_hit(block_i[x*BLOCK_W +: 2], block_i[x*BLOCK_W+2 +: 24],
                                block_i[x*BLOCK_W+34 +: 24], id_q[x]);
            exp_pos[x] = (cnt_q[x] == CNT_END);
            for (int j = 0; j < 4; j++) begin
                if (am_hit(block_i[x*BLOCK_W +: 2], block_i[x*BLOCK_W+2 +: 24],
                           block_i[x*BLOCK_W+34 +: 24], ID_W'(j))) begin
                    hit_any[x] = 1'b1;
                    hit_id[x]  = ID_W'(j);
                end
            end
        end
    end

    // Per-lane hunt/verify/lock; counters only move on valid blocks, block_lock_i loss wins.
    always_comb begin
        valid_d = valid_i;
        block_d = block_i;
        am_d    = '0;
        lock_d  = '0;
        lane_d  = '0;
        col_or  = '0;
        for (int x = 0; x < LANE_N; x++) begin
            state_d[x] = state_q[x];
            cnt_d[x]   = cnt_q[x];
            inv_d[x]   = inv_q[x];
            id_d[x]    = id_q[x];
            if (!block_lock_i[x]) begin
                state_d[x] = HUNT;
                cnt_d[x]   = '0;
                inv_d[x]   = '0;
                id_d[x]    = '0;
            end else if (valid_i) begin
                case (state_q[x])
                    HUNT: begin
                        if (hit_any[x]) begin
                            state_d[x] = VERIFY;
                            id_d[x]    = hit_id[x];
                            cnt_d[x]   = CNT_ONE;
                        end
                    end
                    VERIFY: begin
                        if (!exp_pos[x]) begin
                            cnt_d[x] = cnt_q[x] + CNT_ONE;
                        end else if (hit_cap[x]) begin
                            state_d[x] = LOCKED;
                            cnt_d[x]   = CNT_ONE;
                        end else begin
                            state_d[x] = HUNT;
                            cnt_d[x]   = '0;
                            id_d[x]    = '0;
                        end
                    end
                    LOCKED: begin
                        if (!exp_pos[x]) begin
                            cnt_d[x] = cnt_q[x] + CNT_ONE;
                        end else begin
                            // Flag every expected AM slot, even a corrupted one, so it is stripped downstream.
                            am_d[x]  = 1'b1;
                            cnt_d[x] = CNT_ONE;
                            if (hit_cap[x]) begin
                                inv_d[x] = '0;
                            end else if ((inv_q[x] + INV_ONE) == INV_END) begin
                                state_d[x] = HUNT;
                                cnt_d[x]   = '0;
                                inv_d[x]   = '0;
                                id_d[x]    = '0;
                            end else begin
                                inv_d[x] = inv_q[x] + INV_ONE;
                            end
                        end
                    end
                    default: begin
                        state_d[x] = HUNT;
                        cnt_d[x]   = '0;
                        inv_d[x]   = '0;
                        id_d[x]    = '0;
                    end
                endcase
            end
            lock_d[x] = (state_d[x] == LOCKED);
            if (lock_d[x]) begin
                lane_d[x*LANE_N +: LANE_N] = LANE_N'(1) << id_d[x];
            end
            col_or = col_or | lane_d[x*LANE_N +: LANE_N];
        end
        // Duplicate ids leave a virtual-lane column empty, which blocks alignment.
        aligned_d = (&lock_d) && (&col_or);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int x = 0; x < LANE_N; x++) begin
                state_q[x] <= HUNT;
                cnt_q[x]   <= '0;
                inv_q[x]   <= '0;
                id_q[x]    <= '0;
            end
            valid_q   <= 1'b0;
            block_q   <= '0;
            am_q      <= '0;
            lock_q    <= '0;
            lane_q    <= '0;
            aligned_q <= 1'b0;
        end else begin
            for (int x = 0; x < LANE_N; x++) begin
                state_q[x] <= state_d[x];
                cnt_q[x]   <= cnt_d[x];
                inv_q[x]   <= inv_d[x];
                id_q[x]    <= id_d[x];
            end
            valid_q   <= valid_d;
            block_q   <= block_d;
            am_q      <= am_d;
            lock_q    <= lock_d;
            lane_q    <= lane_d;
            aligned_q <= aligned_d;
        end
    end

    assign valid_o        = valid_q;
    assign block_o        = block_q;
    assign am_o           = am_q;
    assign am_lock_o      = lock_q;
    assign lane_o         = lane_q;
    assign lane_aligned_o = aligned_q;

endmodule
